// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the turn sequencer
// Contents: player_t (P1/P2), turn_state_t (FSM states), DICE_MIN/DICE_MAX.
package game_pkg;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_ROLL = 3'd1,
      MOVE      = 3'd2,
      CHECK     = 3'd3,
      SWITCH    = 3'd4,
      WIN       = 3'd5
   } turn_state_t;

   localparam logic [2:0] DICE_MIN = 3'd1;
   localparam logic [2:0] DICE_MAX = 3'd6;

endpackage

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - frame_tick counter with clear and one-cycle terminal pulse
// Parameter: N   ticks per terminal pulse
// Ports:     clk, rst_n (async active-low)
//            clear  holds the count at 0 and suppresses the pulse
//            tick   frame_tick to be counted
//            pulse  high on the tick that brings the count to N (count wraps to 0)
module frame_divider #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic pulse
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] count;

   assign pulse = tick & ~clear & (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - two-player board-game turn sequencer
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_FRAMES
// frame ticks without an accepted roll.
// Parameters: BOARD_LEN, STEP_FRAMES, BLINK_FRAMES, TIMEOUT_FRAMES
// Ports: clk, rst_n (async active-low), frame_tick, start_game,
//        roll_valid/roll_value/roll_ready (dice handshake),
//        active_player, icon_blink, pos_p1, pos_p2, winner_valid, winner_id
module turn_sequencer
   import game_pkg::*;
#(
   parameter int BOARD_LEN      = 32,
   parameter int STEP_FRAMES    = 8,
   parameter int BLINK_FRAMES   = 16,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_game,
   input  logic       roll_valid,
   input  logic [2:0] roll_value,
   output logic       roll_ready,
   output logic       active_player,
   output logic       icon_blink,
   output logic [5:0] pos_p1,
   output logic [5:0] pos_p2,
   output logic       winner_valid,
   output logic       winner_id
);

   localparam logic [5:0] GOAL = 6'(BOARD_LEN - 1);

   turn_state_t state, state_next;
   player_t     player;
   logic [2:0]  steps;
   logic [5:0]  cur_pos;
   logic        blink_q;
   logic        accept;
   logic        step_pulse;
   logic        blink_pulse;
   logic        last_step;

   assign cur_pos = (player == P1) ? pos_p1 : pos_p2;

   assign accept = (state == WAIT_ROLL) && roll_valid &&
                   (roll_value >= DICE_MIN) && (roll_value <= DICE_MAX);

   // The counter is held clear outside MOVE, so the tick that coincides with
   // roll acceptance is not counted and the first step lands on tick STEP_FRAMES.
   frame_divider #(.N(STEP_FRAMES)) u_step_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_game || (state != MOVE)),
      .tick  (frame_tick),
      .pulse (step_pulse)
   );

   // Blink phase restarts whenever the game restarts or the turn changes hands.
   frame_divider #(.N(BLINK_FRAMES)) u_blink_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_game || !((state == WAIT_ROLL) || (state == MOVE))),
      .tick  (frame_tick),
      .pulse (blink_pulse)
   );

`ifdef TURN_TIMEOUT_EN
   logic timeout_pulse;

   frame_divider #(.N(TIMEOUT_FRAMES)) u_timeout_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_game || (state != WAIT_ROLL)),
      .tick  (frame_tick),
      .pulse (timeout_pulse)
   );
`endif

   // Leave MOVE on the step that uses up the roll or lands on the goal cell;
   // stopping at the goal is what clamps an overshooting roll.
   assign last_step = step_pulse && ((steps <= 3'd1) || (cur_pos >= GOAL - 6'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      roll_ready    = (state == WAIT_ROLL);
      winner_valid  = (state == WIN);
      winner_id     = (state == WIN) ? player : 1'b0;
      icon_blink    = ((state == IDLE) || (state == WIN)) ? 1'b1 : blink_q;
      active_player = player;
      if (start_game) begin
         state_next = WAIT_ROLL;
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            WAIT_ROLL: begin
               if (accept) begin
                  state_next = MOVE;
               end
`ifdef TURN_TIMEOUT_EN
               else if (timeout_pulse) begin
                  state_next = SWITCH;
               end
`endif
            end
            MOVE: begin
               if (last_step) begin
                  state_next = CHECK;
               end
            end
            CHECK:   state_next = (cur_pos == GOAL) ? WIN : SWITCH;
            SWITCH:  state_next = WAIT_ROLL;
            WIN:     state_next = WIN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player  <= P1;
         steps   <= 3'd0;
         pos_p1  <= 6'd0;
         pos_p2  <= 6'd0;
         blink_q <= 1'b1;
      end else if (start_game) begin
         player  <= P1;
         steps   <= 3'd0;
         pos_p1  <= 6'd0;
         pos_p2  <= 6'd0;
         blink_q <= 1'b1;
      end else begin
         case (state)
            WAIT_ROLL: begin
               if (accept) begin
                  steps <= roll_value;
               end
               if (blink_pulse) begin
                  blink_q <= ~blink_q;
               end
            end
            MOVE: begin
               if (step_pulse && (cur_pos < GOAL)) begin
                  steps <= steps - 3'd1;
                  if (player == P1) begin
                     pos_p1 <= pos_p1 + 6'd1;
                  end else begin
                     pos_p2 <= pos_p2 + 6'd1;
                  end
               end
               if (blink_pulse) begin
                  blink_q <= ~blink_q;
               end
            end
            SWITCH: begin
               player  <= (player == P1) ? P2 : P1;
               blink_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
// Build with TURN_TIMEOUT_EN defined to exercise the forfeit path.
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_game = 1'b0;
   logic       roll_valid = 1'b0;
   logic [2:0] roll_value = 3'd0;
   logic       roll_ready;
   logic       active_player;
   logic       icon_blink;
   logic [5:0] pos_p1;
   logic [5:0] pos_p2;
   logic       winner_valid;
   logic       winner_id;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pos[2];
   int exp_act;

   turn_sequencer #(
      .BOARD_LEN     (32),
      .STEP_FRAMES   (8),
      .BLINK_FRAMES  (16),
      .TIMEOUT_FRAMES(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .start_game   (start_game),
      .roll_valid   (roll_valid),
      .roll_value   (roll_value),
      .roll_ready   (roll_ready),
      .active_player(active_player),
      .icon_blink   (icon_blink),
      .pos_p1       (pos_p1),
      .pos_p2       (pos_p2),
      .winner_valid (winner_valid),
      .winner_id    (winner_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
   endtask

   task automatic pulse_start();
      start_game = 1'b1;
      cycle();
      start_game = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, 32'(roll_ready), 0);
      check({tag, "_act"}, 32'(active_player), 0);
      check({tag, "_blink"}, 32'(icon_blink), 1);
      check({tag, "_p1"}, 32'(pos_p1), 0);
      check({tag, "_p2"}, 32'(pos_p2), 0);
      check({tag, "_wv"}, 32'(winner_valid), 0);
      check({tag, "_wid"}, 32'(winner_id), 0);
   endtask

   // Plays one whole roll and compares against the bench's own board model.
   task automatic play_roll(input int v);
      bit done = 0;
      roll_valid = 1'b1;
      roll_value = 3'(v);
      cycle();
      roll_valid = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         cycle();
         if (roll_ready || winner_valid) done = 1;
      end
      check("play_done", 32'(done), 1);
      exp_pos[exp_act] = (exp_pos[exp_act] + v > 31) ? 31 : exp_pos[exp_act] + v;
      if (exp_pos[exp_act] != 31) exp_act = 1 - exp_act;
      check("play_p1", 32'(pos_p1), 32'(exp_pos[0]));
      check("play_p2", 32'(pos_p2), 32'(exp_pos[1]));
      check("play_act", 32'(active_player), 32'(exp_act));
   endtask

   initial begin
      int seq[10];
      #3;
      check_idle_outputs("rst");
      cycle();
      rst_n = 1'b1;
      cycle();
      check("idle_ready", 32'(roll_ready), 0);
      check("idle_blink", 32'(icon_blink), 1);

      pulse_start();
      check("start_ready", 32'(roll_ready), 1);
      check("start_act", 32'(active_player), 0);

      // Illegal dice values are discarded.
      roll_valid = 1'b1;
      roll_value = 3'd0;
      cycle();
      check("roll0_ready", 32'(roll_ready), 1);
      roll_value = 3'd7;
      cycle();
      check("roll7_ready", 32'(roll_ready), 1);

      // Roll 3 with a coincident tick that must not count toward stepping.
      roll_value = 3'd3;
      frame_tick = 1'b1;
      cycle();
      roll_valid = 1'b0;
      frame_tick = 1'b0;
      check("roll3_ready", 32'(roll_ready), 0);
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (i == 7)  check("step_t7", 32'(pos_p1), 0);
         if (i == 8)  check("step_t8", 32'(pos_p1), 1);
         if (i == 14) check("blink_t14", 32'(icon_blink), 1);
         if (i == 15) check("blink_t15", 32'(icon_blink), 0);
         if (i == 16) check("step_t16", 32'(pos_p1), 2);
         if (i == 24) check("step_t24", 32'(pos_p1), 3);
         if (i != 24) cycle();
      end
      check("step_p2", 32'(pos_p2), 0);
      cycle();
      check("sw_act_1cyc", 32'(active_player), 0);
      cycle();
      check("sw_act_2cyc", 32'(active_player), 1);
      check("sw_ready", 32'(roll_ready), 1);
      check("sw_blink", 32'(icon_blink), 1);

      // Play to p2 = 29, then p2 rolls 6 and wins at 31.
      exp_pos[0] = 3;
      exp_pos[1] = 0;
      exp_act = 1;
      seq = '{6, 6, 6, 6, 6, 6, 6, 5, 5, 1};
      for (int k = 0; k < 10; k++) play_roll(seq[k]);
      check("pre_win_p2", 32'(pos_p2), 29);
      play_roll(6);
      check("win_p2", 32'(pos_p2), 31);
      check("win_valid", 32'(winner_valid), 1);
      check("win_id", 32'(winner_id), 1);
      check("win_ready", 32'(roll_ready), 0);
      check("win_blink", 32'(icon_blink), 1);
      roll_valid = 1'b1;
      roll_value = 3'd4;
      for (int i = 0; i < 20; i++) tick();
      roll_valid = 1'b0;
      check("win_hold_valid", 32'(winner_valid), 1);
      check("win_hold_ready", 32'(roll_ready), 0);
      check("win_hold_p2", 32'(pos_p2), 31);

      // Restart from WIN, then restart again mid-MOVE with pos_p1 = 5.
      pulse_start();
      check("rs_wv", 32'(winner_valid), 0);
      check("rs_p2", 32'(pos_p2), 0);
      check("rs_ready", 32'(roll_ready), 1);
      exp_pos[0] = 0;
      exp_pos[1] = 0;
      exp_act = 0;
      play_roll(5);
      play_roll(1);
      roll_valid = 1'b1;
      roll_value = 3'd4;
      cycle();
      roll_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("mid_p1", 32'(pos_p1), 5);
      check("mid_ready", 32'(roll_ready), 0);
      pulse_start();
      check("mid_rs_p1", 32'(pos_p1), 0);
      check("mid_rs_p2", 32'(pos_p2), 0);
      check("mid_rs_act", 32'(active_player), 0);
      check("mid_rs_ready", 32'(roll_ready), 1);

      // Asynchronous reset in the middle of a move.
      roll_valid = 1'b1;
      roll_value = 3'd4;
      cycle();
      roll_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("arst_pre_p1", 32'(pos_p1), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("arst");
      cycle();
      rst_n = 1'b1;
      cycle();
      check_idle_outputs("arst_post");

      pulse_start();
`ifdef TURN_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i != 4) cycle();
      end
      check("to_ready", 32'(roll_ready), 0);
      cycle();
      check("to_act", 32'(active_player), 1);
      check("to_p1", 32'(pos_p1), 0);
      check("to_ready2", 32'(roll_ready), 1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         cycle();
      end
      roll_valid = 1'b1;
      roll_value = 3'd2;
      tick();
      roll_valid = 1'b0;
      check("to_race_ready", 32'(roll_ready), 0);
      cycle();
      cycle();
      check("to_race_act", 32'(active_player), 1);
      check("to_race_ready2", 32'(roll_ready), 0);
`else
      for (int i = 0; i < 10; i++) begin
         tick();
         cycle();
      end
      check("nto_ready", 32'(roll_ready), 1);
      check("nto_act", 32'(active_player), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
